// File: rtl/regbank_pkg.sv
// regbank_pkg: shared definitions for the 4-entry register bank.
//   REG_IDX_W - width of a register index
//   REG_CNT   - number of entries in the bank
//   reg_idx_t - register index type used for the read and write addresses
package regbank_pkg;

    localparam int REG_IDX_W = 2;
    localparam int REG_CNT   = 4;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

endpackage : regbank_pkg

// File: rtl/decoder2x4.sv
// decoder2x4: combinational 2-to-4 one-hot decoder.
//   a - input, index MSB
//   b - input, index LSB
//   f - output, one-hot; f[i] is high when {a,b} == i
module decoder2x4 (
    input  logic       a,
    input  logic       b,
    output logic [3:0] f
);

    // One-hot decode of the 2-bit index {a,b}.
    always_comb begin
        f = 4'b0000;
        case ({a, b})
            2'b00:   f = 4'b0001;
            2'b01:   f = 4'b0010;
            2'b10:   f = 4'b0100;
            2'b11:   f = 4'b1000;
            default: f = 4'b0000;
        endcase
    end

endmodule : decoder2x4

// File: rtl/regbank4_1w2r.sv
// regbank4_1w2r: 4-entry register bank, one write port, two registered read ports.
//   clk, rst_n          - clock and synchronous active-low reset
//   we, waddr, wdata    - write request, index and data
//   re_a/raddr_a        - read request and index, port A (same for port B)
//   rdata_a/rvalid_a    - registered read data and valid, port A (same for port B)
//   written             - sticky per-entry "has been written since reset" mask
//   wr_drop             - one-cycle pulse when a write to the hardwired-zero entry is dropped
// Reads see a write issued in the same cycle (write-first bypass).
module regbank4_1w2r
    import regbank_pkg::*;
#(
    parameter int DW      = 32,
    parameter bit ZERO_R0 = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we,
    input  reg_idx_t           waddr,
    input  logic [DW-1:0]      wdata,
    input  logic               re_a,
    input  logic               re_b,
    input  reg_idx_t           raddr_a,
    input  reg_idx_t           raddr_b,
    output logic [DW-1:0]      rdata_a,
    output logic [DW-1:0]      rdata_b,
    output logic               rvalid_a,
    output logic               rvalid_b,
    output logic [REG_CNT-1:0] written,
    output logic               wr_drop
);

    // Entry 0 is excluded from write enables when it is hardwired to zero.
    localparam logic [REG_CNT-1:0] WEN_MASK = ZERO_R0 ? 4'b1110 : 4'b1111;

    logic [REG_CNT-1:0] dec_f_s;
    logic [REG_CNT-1:0] wen_s;

    logic [DW-1:0]      mem_q [REG_CNT];
    logic [DW-1:0]      mem_d [REG_CNT];
    logic [DW-1:0]      rdata_a_q, rdata_a_d;
    logic [DW-1:0]      rdata_b_q, rdata_b_d;
    logic               rvalid_a_q, rvalid_a_d;
    logic               rvalid_b_q, rvalid_b_d;
    logic [REG_CNT-1:0] written_q, written_d;
    logic               wr_drop_q, wr_drop_d;

    decoder2x4 u_wdec (
        .a (waddr[1]),
        .b (waddr[0]),
        .f (dec_f_s)
    );

    // Write enables, next array contents, read muxes and status next-state.
    always_comb begin
        wen_s = dec_f_s & {REG_CNT{we}} & WEN_MASK;

        for (int i = 0; i < REG_CNT; i++) begin
            if (wen_s[i]) begin
                mem_d[i] = wdata;
            end else begin
                mem_d[i] = mem_q[i];
            end
        end

        // Reading from mem_d rather than mem_q gives the write-first bypass.
        if (!re_a) begin
            rdata_a_d = rdata_a_q;
        end else if (ZERO_R0 && (raddr_a == 2'd0)) begin
            rdata_a_d = '0;
        end else begin
            rdata_a_d = mem_d[raddr_a];
        end

        if (!re_b) begin
            rdata_b_d = rdata_b_q;
        end else if (ZERO_R0 && (raddr_b == 2'd0)) begin
            rdata_b_d = '0;
        end else begin
            rdata_b_d = mem_d[raddr_b];
        end

        rvalid_a_d = re_a;
        rvalid_b_d = re_b;
        written_d  = written_q | wen_s;
        wr_drop_d  = ZERO_R0 && we && (waddr == 2'd0);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_CNT; i++) begin
                mem_q[i] <= '0;
            end
            rdata_a_q  <= '0;
            rdata_b_q  <= '0;
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
            written_q  <= 4'b0000;
            wr_drop_q  <= 1'b0;
        end else begin
            for (int i = 0; i < REG_CNT; i++) begin
                mem_q[i] <= mem_d[i];
            end
            rdata_a_q  <= rdata_a_d;
            rdata_b_q  <= rdata_b_d;
            rvalid_a_q <= rvalid_a_d;
            rvalid_b_q <= rvalid_b_d;
            written_q  <= written_d;
            wr_drop_q  <= wr_drop_d;
        end
    end

    assign rdata_a  = rdata_a_q;
    assign rdata_b  = rdata_b_q;
    assign rvalid_a = rvalid_a_q;
    assign rvalid_b = rvalid_b_q;
    assign written  = written_q;
    assign wr_drop  = wr_drop_q;

endmodule : regbank4_1w2r

// File: tb/tb_regbank4_1w2r.sv
// tb_regbank4_1w2r: bench for regbank4_1w2r. Two instances share the stimulus:
// index 0 has ZERO_R0=0, index 1 has ZERO_R0=1. A behavioural model of the
// register file is checked against both on every cycle, and directed literal
// expectations pin the model at key points of the sequence.
module tb_regbank4_1w2r;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we;
    logic [1:0]  waddr;
    logic [31:0] wdata;
    logic        re_a, re_b;
    logic [1:0]  raddr_a, raddr_b;

    logic [31:0] rd_a [2];
    logic [31:0] rd_b [2];
    logic        rv_a [2];
    logic        rv_b [2];
    logic [3:0]  wr_m [2];
    logic        drop [2];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    regbank4_1w2r #(.DW(32), .ZERO_R0(1'b0)) dut_z0 (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .re_a(re_a), .re_b(re_b), .raddr_a(raddr_a), .raddr_b(raddr_b),
        .rdata_a(rd_a[0]), .rdata_b(rd_b[0]), .rvalid_a(rv_a[0]), .rvalid_b(rv_b[0]),
        .written(wr_m[0]), .wr_drop(drop[0])
    );

    regbank4_1w2r #(.DW(32), .ZERO_R0(1'b1)) dut_z1 (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .re_a(re_a), .re_b(re_b), .raddr_a(raddr_a), .raddr_b(raddr_b),
        .rdata_a(rd_a[1]), .rdata_b(rd_b[1]), .rvalid_a(rv_a[1]), .rvalid_b(rv_b[1]),
        .written(wr_m[1]), .wr_drop(drop[1])
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Behavioural model: array contents plus the expected outputs after the next edge.
    logic [31:0] m_mem [2][4];
    logic [31:0] e_ra [2];
    logic [31:0] e_rb [2];
    logic        e_va [2];
    logic        e_vb [2];
    logic [3:0]  e_wr [2];
    logic        e_dr [2];

    initial begin : compare_proc
        bit have_p;
        have_p = 1'b0;
        forever begin
            @(negedge clk);
            if (have_p) begin
                for (int z = 0; z < 2; z++) begin
                    chk($sformatf("model z%0d rdata_a", z), rd_a[z], e_ra[z]);
                    chk($sformatf("model z%0d rdata_b", z), rd_b[z], e_rb[z]);
                    chk($sformatf("model z%0d rvalid_a", z), {31'd0, rv_a[z]}, {31'd0, e_va[z]});
                    chk($sformatf("model z%0d rvalid_b", z), {31'd0, rv_b[z]}, {31'd0, e_vb[z]});
                    chk($sformatf("model z%0d written", z), {28'd0, wr_m[z]}, {28'd0, e_wr[z]});
                    chk($sformatf("model z%0d wr_drop", z), {31'd0, drop[z]}, {31'd0, e_dr[z]});
                end
            end
            // Advance the model by the edge that follows, using the inputs now stable.
            for (int z = 0; z < 2; z++) begin
                if (rst_n !== 1'b1) begin
                    for (int k = 0; k < 4; k++) m_mem[z][k] = 32'd0;
                    e_ra[z] = 32'd0; e_rb[z] = 32'd0;
                    e_va[z] = 1'b0;  e_vb[z] = 1'b0;
                    e_wr[z] = 4'd0;  e_dr[z] = 1'b0;
                end else begin
                    e_dr[z] = (z == 1) && we && (waddr == 2'd0);
                    if (we && !e_dr[z]) begin
                        m_mem[z][waddr] = wdata;
                        e_wr[z][waddr]  = 1'b1;
                    end
                    if (re_a) e_ra[z] = (z == 1 && raddr_a == 2'd0) ? 32'd0 : m_mem[z][raddr_a];
                    if (re_b) e_rb[z] = (z == 1 && raddr_b == 2'd0) ? 32'd0 : m_mem[z][raddr_b];
                    e_va[z] = re_a;
                    e_vb[z] = re_b;
                end
            end
            have_p = 1'b1;
        end
    end

    // Apply one cycle of inputs, wait for the edge, return just after it.
    task automatic drive(input logic rst, input logic w, input logic [1:0] wa, input logic [31:0] wd,
                         input logic ea, input logic [1:0] ra, input logic eb, input logic [1:0] rb);
        rst_n = rst; we = w; waddr = wa; wdata = wd;
        re_a = ea; raddr_a = ra; re_b = eb; raddr_b = rb;
        @(posedge clk);
        #1;
    endtask

    initial begin : stim_proc
        logic [31:0] v;
        drive(1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 2'd0, 1'b0, 2'd0);
        drive(1'b0, 1'b0, 2'd0, 32'd0, 1'b1, 2'd1, 1'b1, 2'd2);
        chk("reset written z0", {28'd0, wr_m[0]}, 32'd0);
        chk("reset rvalid_a z1", {31'd0, rv_a[1]}, 32'd0);

        // Read every index on both ports straight after reset.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 2'd0, 32'd0, 1'b1, 2'(i), 1'b1, 2'(3 - i));
            chk("post-reset rdata_a z0", rd_a[0], 32'd0);
            chk("post-reset rvalid_b z1", {31'd0, rv_b[1]}, 32'd1);
        end

        // Fill all four entries.
        for (int i = 0; i < 4; i++) begin
            v = 32'h11 * (i + 1);
            drive(1'b1, 1'b1, 2'(i), v, 1'b0, 2'd0, 1'b0, 2'd0);
            if (i == 0) begin
                chk("drop pulse z1", {31'd0, drop[1]}, 32'd1);
                chk("no drop z0", {31'd0, drop[0]}, 32'd0);
            end
            if (i == 1) chk("drop one-cycle z1", {31'd0, drop[1]}, 32'd0);
        end
        chk("written all z0", {28'd0, wr_m[0]}, 32'hF);
        chk("written no entry0 z1", {28'd0, wr_m[1]}, 32'hE);

        for (int i = 0; i < 4; i++) begin
            v = 32'h11 * (i + 1);
            drive(1'b1, 1'b0, 2'd0, 32'd0, 1'b1, 2'(i), 1'b0, 2'd0);
            chk("readback z0", rd_a[0], v);
            chk("readback z1", rd_a[1], (i == 0) ? 32'd0 : v);
        end

        // Same-cycle write and read of index 2.
        drive(1'b1, 1'b1, 2'd2, 32'hDEADBEEF, 1'b1, 2'd2, 1'b0, 2'd0);
        chk("bypass z0", rd_a[0], 32'hDEADBEEF);
        chk("bypass z1", rd_a[1], 32'hDEADBEEF);

        // Write to index 0: dropped only when entry 0 is hardwired.
        drive(1'b1, 1'b1, 2'd0, 32'h0000FFFF, 1'b0, 2'd0, 1'b0, 2'd0);
        chk("zero write drop z1", {31'd0, drop[1]}, 32'd1);
        drive(1'b1, 1'b0, 2'd0, 32'd0, 1'b1, 2'd0, 1'b1, 2'd0);
        chk("read r0 z1", rd_a[1], 32'd0);
        chk("read r0 z0", rd_b[0], 32'h0000FFFF);
        chk("written0 stays z1", {28'd0, wr_m[1]}, 32'hE);

        // Both ports read index 3 while index 1 is written, then read index 1.
        drive(1'b1, 1'b1, 2'd1, 32'h55, 1'b1, 2'd3, 1'b1, 2'd3);
        chk("dual read a", rd_a[0], 32'h44);
        chk("dual read b", rd_b[1], 32'h44);
        drive(1'b1, 1'b0, 2'd0, 32'd0, 1'b1, 2'd1, 1'b0, 2'd0);
        chk("read new r1", rd_a[1], 32'h55);

        // Back-to-back writes to index 2, read in the second write's cycle, then idle hold.
        drive(1'b1, 1'b1, 2'd2, 32'hA1, 1'b0, 2'd0, 1'b0, 2'd0);
        drive(1'b1, 1'b1, 2'd2, 32'hA2, 1'b1, 2'd2, 1'b0, 2'd0);
        chk("last write wins", rd_a[0], 32'hA2);
        drive(1'b1, 1'b0, 2'd0, 32'd0, 1'b0, 2'd1, 1'b0, 2'd0);
        chk("idle rvalid low", {31'd0, rv_a[0]}, 32'd0);
        chk("idle rdata holds", rd_a[1], 32'hA2);

        // Reset during a write and a read, then write/read on the first released edge.
        drive(1'b1, 1'b1, 2'd1, 32'h77, 1'b0, 2'd0, 1'b0, 2'd0);
        drive(1'b0, 1'b1, 2'd3, 32'h99, 1'b1, 2'd3, 1'b1, 2'd1);
        chk("reset wins rvalid", {31'd0, rv_a[0]}, 32'd0);
        chk("reset clears written", {28'd0, wr_m[0]}, 32'd0);
        drive(1'b1, 1'b1, 2'd3, 32'hC3, 1'b1, 2'd3, 1'b1, 2'd1);
        chk("first edge bypass", rd_a[0], 32'hC3);
        chk("reset cleared r1", rd_b[0], 32'd0);
        chk("written after reset", {28'd0, wr_m[0]}, 32'h8);

        drive(1'b1, 1'b0, 2'd0, 32'd0, 1'b1, 2'd3, 1'b1, 2'd2);
        drive(1'b1, 1'b0, 2'd0, 32'd0, 1'b0, 2'd0, 1'b0, 2'd0);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_regbank4_1w2r
